// File: rtl/switch_confirm_input.sv
// switch_confirm_input
// Conditions the 16 board switches and the confirm button for the CPU
// switch read path. Both are synchronized into the clock domain, and the
// button is debounced. Each accepted press captures a switch snapshot and
// raises data_valid. The CPU read strobe (rd_ack) clears data_valid again.
//
// Optional build macro: CONFIRM_REPEAT_EN
//   When defined, holding the button re-issues the accept action every
//   REPEAT_CYCLES clocks. When undefined, a held button gives one pulse only.
//
// Debounce FSM:
//   state        | meaning
//   IDLE         | button released and settled
//   PRESS_WAIT   | button seen high, counting stable cycles before accepting
//   PRESSED      | press accepted, button still held
//   RELEASE_WAIT | button seen low, counting stable cycles before re-arming

module switch_confirm_input #(
  parameter int SW_WIDTH        = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int CNT_W           = 18,
  parameter int REPEAT_CYCLES   = 250000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches_raw,
  input  logic                confirm_raw,
  input  logic                rd_ack,
  output logic [SW_WIDTH-1:0] sw_live,
  output logic [SW_WIDTH-1:0] sw_data,
  output logic                confirm_pulse,
  output logic                data_valid,
  output logic                overrun
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync;
  logic [SYNC_STAGES-1:0]               btn_sync;
  logic                                 btn_s;

  // Shift raw inputs through SYNC_STAGES flops; stage 0 may go metastable.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_sync  <= '0;
      btn_sync <= '0;
    end else begin
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], switches_raw};
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], confirm_raw};
    end
  end

  assign sw_live = sw_sync[SYNC_STAGES-1];
  assign btn_s   = btn_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept_deb;
  logic             repeat_fire;
  logic             accept;

  // Saturating increment; the debounce counter must never wrap back to a
  // value that could match the terminal count a second time.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // State and debounce counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter decode; accept_deb marks the PRESS_WAIT->PRESSED edge.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept_deb = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_TC) begin
          state_nxt  = PRESSED;
          cnt_nxt    = '0;
          accept_deb = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          // Bounce during release: return to PRESSED without a new pulse.
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_TC) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Auto-repeat (optional)
  // ---------------------------------------------------------------------
`ifdef CONFIRM_REPEAT_EN
  // Terminal value is one less than the period because the count restarts
  // at zero on the same edge it fires, giving exactly REPEAT_CYCLES spacing.
  localparam logic [CNT_W-1:0] REP_TC = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt;

  assign repeat_fire = (state == PRESSED) && btn_s && (rep_cnt == REP_TC);

  // Repeat counter runs only while the button is held in PRESSED.
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt <= '0;
    end else if ((state == PRESSED) && btn_s) begin
      rep_cnt <= repeat_fire ? '0 : rep_cnt + CNT_ONE;
    end else begin
      rep_cnt <= '0;
    end
  end
`else
  logic unused_repeat;

  assign repeat_fire   = 1'b0;
  assign unused_repeat = ^CNT_W'(REPEAT_CYCLES);
`endif

  assign accept = accept_deb | repeat_fire;

  // ---------------------------------------------------------------------
  // Snapshot / handshake outputs
  // ---------------------------------------------------------------------

  // Accept beats a same-cycle read; a read alone clears the pending flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_data       <= '0;
      confirm_pulse <= 1'b0;
      data_valid    <= 1'b0;
      overrun       <= 1'b0;
    end else if (accept) begin
      sw_data       <= sw_live;
      confirm_pulse <= 1'b1;
      data_valid    <= 1'b1;
      overrun       <= data_valid & ~rd_ack;
    end else begin
      confirm_pulse <= 1'b0;
      if (rd_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_confirm_input.sv
// Testbench for switch_confirm_input: scenario tasks with inline checks plus
// a scoreboard queue of expected snapshots consumed on every confirm_pulse.
module tb_switch_confirm_input;

  localparam int SW_WIDTH        = 16;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_W           = 18;
  localparam int REPEAT_CYCLES   = 10;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [SW_WIDTH-1:0] switches_raw = '0;
  logic                confirm_raw = 1'b0;
  logic                rd_ack = 1'b0;
  logic [SW_WIDTH-1:0] sw_live;
  logic [SW_WIDTH-1:0] sw_data;
  logic                confirm_pulse;
  logic                data_valid;
  logic                overrun;

  typedef struct packed {
    logic [SW_WIDTH-1:0] sw;
    logic                ovr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   pulse_cnt = 0;
  logic exp_valid = 1'b0;

  switch_confirm_input #(
    .SW_WIDTH       (SW_WIDTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .REPEAT_CYCLES  (REPEAT_CYCLES)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .switches_raw (switches_raw),
    .confirm_raw  (confirm_raw),
    .rd_ack       (rd_ack),
    .sw_live      (sw_live),
    .sw_data      (sw_data),
    .confirm_pulse(confirm_pulse),
    .data_valid   (data_valid),
    .overrun      (overrun)
  );

  always #5 clock = ~clock;

  // Scoreboard: every pulse must match the oldest pending expectation.
  always @(negedge clock) begin
    if (confirm_pulse) begin
      pulse_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got pulse with sw_data=%h, expected no pulse", sw_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (sw_data !== mon_e.sw) begin
          bad++;
          $display("FAIL sb_sw_data: got %h expected %h", sw_data, mon_e.sw);
        end
        total++;
        if (overrun !== mon_e.ovr) begin
          bad++;
          $display("FAIL sb_overrun: got %b expected %b", overrun, mon_e.ovr);
        end
        total++;
        if (data_valid !== 1'b1) begin
          bad++;
          $display("FAIL sb_data_valid: got %b expected 1", data_valid);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_press(input logic [SW_WIDTH-1:0] sw);
    exp_t e;
    e.sw  = sw;
    e.ovr = exp_valid;
    exp_q.push_back(e);
    exp_valid = 1'b1;
  endtask

  task automatic press_release(input logic [SW_WIDTH-1:0] sw, input int hold);
    switches_raw = sw;
    repeat (3) step();
    expect_press(sw);
    confirm_raw = 1'b1;
    repeat (hold) step();
    confirm_raw = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    confirm_raw = 1'b1;
    switches_raw = 16'hFFFF;
    rd_ack = 1'b0;
    repeat (3) step();
    total++;
    if ({sw_live, sw_data, confirm_pulse, data_valid, overrun} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got sw_live=%h sw_data=%h pulse=%b dv=%b ovr=%b expected all 0",
               sw_live, sw_data, confirm_pulse, data_valid, overrun);
    end
    reset = 1'b0;
    confirm_raw = 1'b0;
    step();
    total++;
    if (sw_live !== 16'h0000) begin
      bad++;
      $display("FAIL sync_latency_1: got sw_live=%h expected 0000", sw_live);
    end
    step();
    total++;
    if (sw_live !== 16'hFFFF) begin
      bad++;
      $display("FAIL sync_latency_2: got sw_live=%h expected ffff", sw_live);
    end
    repeat (4) step();
  endtask

  task automatic test_bounce();
    int pre;
    logic [7:0] pat;
    pre = pulse_cnt;
    pat = 8'b1100_1100;
    for (int i = 7; i >= 0; i--) begin
      confirm_raw = pat[i];
      step();
    end
    confirm_raw = 1'b0;
    repeat (12) step();
    total++;
    if (pulse_cnt !== pre) begin
      bad++;
      $display("FAIL bounce_pulses: got %0d pulses expected 0", pulse_cnt - pre);
    end
    total++;
    if (data_valid !== 1'b0) begin
      bad++;
      $display("FAIL bounce_data_valid: got %b expected 0", data_valid);
    end
  endtask

  task automatic test_clean_press();
    int pre;
    int first;
    logic [4:0] rel;
    pre = pulse_cnt;
    first = 0;
    switches_raw = 16'h00A5;
    repeat (3) step();
    expect_press(16'h00A5);
    confirm_raw = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (confirm_pulse && first == 0) first = i;
    end
    rel = 5'b00110;
    for (int i = 4; i >= 0; i--) begin
      confirm_raw = rel[i];
      repeat (2) step();
    end
    repeat (12) step();
    total++;
    if (first !== 7) begin
      bad++;
      $display("FAIL press_latency: got pulse at cycle %0d expected 7", first);
    end
    total++;
    if (pulse_cnt - pre !== 1) begin
      bad++;
      $display("FAIL press_pulses: got %0d expected 1", pulse_cnt - pre);
    end
    total++;
    if (sw_data !== 16'h00A5 || data_valid !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL press_state: got sw_data=%h dv=%b ovr=%b expected 00a5 1 0",
               sw_data, data_valid, overrun);
    end
  endtask

  task automatic test_handshake();
    int pre;
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    exp_valid = 1'b0;
    total++;
    if (data_valid !== 1'b0 || overrun !== 1'b0 || sw_data !== 16'h00A5) begin
      bad++;
      $display("FAIL read_clear: got dv=%b ovr=%b sw_data=%h expected 0 0 00a5",
               data_valid, overrun, sw_data);
    end
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    step();
    total++;
    if (data_valid !== 1'b0 || sw_data !== 16'h00A5) begin
      bad++;
      $display("FAIL idle_read: got dv=%b sw_data=%h expected 0 00a5", data_valid, sw_data);
    end
    pre = pulse_cnt;
    press_release(16'h1234, 10);
    total++;
    if (data_valid !== 1'b1 || sw_data !== 16'h1234 || overrun !== 1'b0 || pulse_cnt - pre !== 1) begin
      bad++;
      $display("FAIL second_press: got dv=%b sw_data=%h ovr=%b pulses=%0d expected 1 1234 0 1",
               data_valid, sw_data, overrun, pulse_cnt - pre);
    end
    press_release(16'h5678, 10);
    total++;
    if (overrun !== 1'b1 || sw_data !== 16'h5678 || data_valid !== 1'b1) begin
      bad++;
      $display("FAIL overrun_press: got ovr=%b sw_data=%h dv=%b expected 1 5678 1",
               overrun, sw_data, data_valid);
    end
  endtask

  task automatic test_simultaneous();
    switches_raw = 16'h9ABC;
    repeat (3) step();
    exp_valid = 1'b0;
    expect_press(16'h9ABC);
    confirm_raw = 1'b1;
    repeat (6) step();
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    total++;
    if (confirm_pulse !== 1'b1 || data_valid !== 1'b1 || overrun !== 1'b0 || sw_data !== 16'h9ABC) begin
      bad++;
      $display("FAIL read_vs_accept: got pulse=%b dv=%b ovr=%b sw_data=%h expected 1 1 0 9abc",
               confirm_pulse, data_valid, overrun, sw_data);
    end
    repeat (4) step();
    confirm_raw = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_reset_mid_debounce();
    int pre;
    int first;
    pre = pulse_cnt;
    first = 0;
    switches_raw = 16'h0F0F;
    repeat (3) step();
    confirm_raw = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    step();
    total++;
    if (data_valid !== 1'b0 || overrun !== 1'b0 || sw_data !== 16'h0000 || pulse_cnt !== pre) begin
      bad++;
      $display("FAIL mid_reset: got dv=%b ovr=%b sw_data=%h pulses=%0d expected 0 0 0000 0",
               data_valid, overrun, sw_data, pulse_cnt - pre);
    end
    reset = 1'b0;
    exp_valid = 1'b0;
    expect_press(16'h0F0F);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (confirm_pulse && first == 0) first = i;
    end
    total++;
    if (first !== 7) begin
      bad++;
      $display("FAIL post_reset_debounce: got pulse at cycle %0d expected 7", first);
    end
    confirm_raw = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_hold();
    int pre;
    int n_exp;
    pre = pulse_cnt;
    switches_raw = 16'h1357;
    repeat (3) step();
    expect_press(16'h1357);
    n_exp = 1;
`ifdef CONFIRM_REPEAT_EN
    for (int i = 0; i < 3; i++) expect_press(16'h1357);
    n_exp = 4;
`endif
    confirm_raw = 1'b1;
    repeat (42) step();
    confirm_raw = 1'b0;
    repeat (12) step();
    total++;
    if (pulse_cnt - pre !== n_exp) begin
      bad++;
      $display("FAIL hold_pulses: got %0d expected %0d", pulse_cnt - pre, n_exp);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_handshake();
    test_simultaneous();
    test_reset_mid_debounce();
    test_hold();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL missing_pulses: got %0d expectations left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule
